// File: rtl/act_unit_pl.sv
// Three-stage pipelined piecewise-linear activation unit (PLAN sigmoid, tanh, relu, bypass)
// with a valid/ready stream, back-pressure and an opaque sideband tag.
module act_unit_pl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FRAC_W = 5,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned W  = DATA_W + 3;
  localparam int unsigned SC = FRAC_W - 5;

  // Constants are integer multiples of 1/32, rescaled to FRAC_W fractional bits
  localparam logic [W-1:0] C_ONE = W'(32 << SC);
  localparam logic [W-1:0] C_T2  = W'(76 << SC);
  localparam logic [W-1:0] C_T3  = W'(160 << SC);
  localparam logic [W-1:0] C_O0  = W'(16 << SC);
  localparam logic [W-1:0] C_O1  = W'(20 << SC);
  localparam logic [W-1:0] C_O2  = W'(27 << SC);

  localparam logic [1:0] M_SIG  = 2'd0;
  localparam logic [1:0] M_TANH = 2'd1;
  localparam logic [1:0] M_RELU = 2'd2;

  logic adv;

  logic              v1, neg1;
  logic [1:0]        mode1, seg1;
  logic [TAG_W-1:0]  tag1;
  logic [DATA_W-1:0] x1;
  logic [W-1:0]      a1;

  logic              v2, neg2;
  logic [1:0]        mode2;
  logic [TAG_W-1:0]  tag2;
  logic [DATA_W-1:0] x2;
  logic [W-1:0]      p2;

  logic [W-1:0]      x_ext, z_c, a_c, p_c, s_c;
  logic [1:0]        seg_c;
  logic [DATA_W-1:0] r_c;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // S1: pre-scale for tanh, magnitude and segment select
  always_comb begin
    x_ext = {{3{in_data[DATA_W-1]}}, in_data};
    z_c   = (in_mode == M_TANH) ? (x_ext << 1) : x_ext;
    a_c   = z_c[W-1] ? (~z_c + W'(1)) : z_c;
    if (a_c >= C_T3)       seg_c = 2'd3;
    else if (a_c >= C_T2)  seg_c = 2'd2;
    else if (a_c >= C_ONE) seg_c = 2'd1;
    else                   seg_c = 2'd0;
  end

  // S2: half-curve linear piece for non-negative magnitude
  always_comb begin
    case (seg1)
      2'd3:    p_c = C_ONE;
      2'd2:    p_c = (a1 >> 5) + C_O2;
      2'd1:    p_c = (a1 >> 3) + C_O1;
      default: p_c = (a1 >> 2) + C_O0;
    endcase
  end

  // S3: reflect around 0.5 for negative inputs, then per-mode post-processing
  always_comb begin
    s_c = neg2 ? (C_ONE - p2) : p2;
    case (mode2)
      M_SIG:   r_c = DATA_W'(s_c);
      M_TANH:  r_c = DATA_W'((s_c << 1) - C_ONE);
      M_RELU:  r_c = x2[DATA_W-1] ? '0 : x2;
      default: r_c = x2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      neg1      <= 1'b0;
      mode1     <= '0;
      seg1      <= '0;
      tag1      <= '0;
      x1        <= '0;
      a1        <= '0;
      v2        <= 1'b0;
      neg2      <= 1'b0;
      mode2     <= '0;
      tag2      <= '0;
      x2        <= '0;
      p2        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      v1        <= in_valid & in_ready;
      neg1      <= z_c[W-1];
      mode1     <= in_mode;
      seg1      <= seg_c;
      tag1      <= in_tag;
      x1        <= in_data;
      a1        <= a_c;
      v2        <= v1;
      neg2      <= neg1;
      mode2     <= mode1;
      tag2      <= tag1;
      x2        <= x1;
      p2        <= p_c;
      out_valid <= v2;
      out_data  <= r_c;
      out_tag   <= tag2;
    end
  end

endmodule
